result_deser: RTL and testbench
===============================

RESULT_DESER -- requirements
Module: result_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per assembled word (legal range 2..32).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of output FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port c_in, input, 1 bit: serial result bit from the upstream registered adder stage.
REQ-006 SHALL have port c_vld, input, 1 bit: c_in is valid this cycle; there is no backpressure to upstream.
REQ-007 SHALL have port flush, input, 1 bit: synchronous discard of the partial word.
REQ-008 SHALL have port data_o, output, WIDTH bits: head FIFO word.
REQ-009 SHALL have port data_vld_o, output, 1 bit: FIFO is not empty.
REQ-010 SHALL have port data_rdy_i, input, 1 bit: consumer accepts the head word.
REQ-011 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-012 SHALL have port ovf_o, output, 1 bit: sticky overflow flag.

Function
REQ-013 SHALL shift c_in into the shift register LSB-first on each cycle with c_vld=1; bit k of the word is the k-th accepted bit.
REQ-014 SHALL use the FSM states IDLE (bit count 0), SHIFT (bit count 1..WIDTH-1) and LAST, with transitions as follows: IDLE->SHIFT on c_vld; SHIFT->LAST when bit WIDTH-1 is accepted; LAST->SHIFT if c_vld, else LAST->IDLE.
REQ-015 SHALL, in LAST, push the assembled word into the FIFO, so that data_vld_o rises one cycle after the edge that accepted the final bit when the FIFO was empty.
REQ-016 SHALL accept bits continuously with no bubble: a bit arriving in LAST is bit 0 of the next word.
REQ-017 SHALL pop the FIFO on each cycle where data_vld_o=1 and data_rdy_i=1; data_o SHALL be 0 whenever the FIFO is empty.
REQ-018 SHALL drop a push that arrives while the FIFO is full and no pop occurs, leave the FIFO contents unchanged, and set ovf_o to 1 until reset.
REQ-019 SHALL accept both a push and a pop in the same cycle when the FIFO is full, leaving level_o unchanged.
REQ-020 SHALL, on flush=1, return the FSM to IDLE and clear the bit count; FIFO contents SHALL be untouched, and any c_vld bit in the same cycle SHALL be discarded.
REQ-021 SHALL let a flush in the LAST state still complete that cycle's push.
REQ-022 SHALL wrap the FIFO read and write pointers modulo DEPTH.

Reset
REQ-023 SHALL, on rst_n=0, immediately clear the FSM to IDLE, clear the shift register and FIFO pointers, and drive data_o=0, data_vld_o=0, level_o=0 and ovf_o=0.
REQ-024 SHALL discard any partial word when reset is asserted mid-word; the first bit after reset release is bit 0.

Configuration
REQ-025 SHALL provide the macro RESULT_DESER_PARITY_EN; when defined, each FIFO entry SHALL store an extra even-parity bit, output on port par_o (1 bit, 0 when empty).
REQ-026 SHALL, when RESULT_DESER_PARITY_EN is undefined, not have port par_o and not store a parity bit.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, SHIFT, LAST) and the default WIDTH and DEPTH constants in package result_deser_pkg.
REQ-028 SHALL implement the FIFO as sub-module result_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/level).

Verification
REQ-029 SHALL verify: WIDTH=8, 8 valid bits 1,0,1,1,0,0,0,1 -> data_o=8'h8D with data_vld_o rising one cycle after the 8th bit.
REQ-030 SHALL verify: 16 back-to-back valid bits forming 8'hFF then 8'h00, with data_rdy_i=1 -> two words, no gap in acceptance, level_o never exceeds 1.
REQ-031 SHALL verify: data_rdy_i=0 and 5 words pushed with DEPTH=4 -> level_o=4, ovf_o=1, and the 5th word absent.
REQ-032 SHALL verify: 3 bits, then flush, then 8 bits of 8'h5A -> data_o=8'h5A.
REQ-033 SHALL verify: rst_n pulsed low after 4 bits -> all outputs 0 immediately; the next 8 bits of 8'h3C yield 8'h3C.
REQ-034 SHALL verify: with RESULT_DESER_PARITY_EN defined, word 8'h07 -> par_o=1.

Source files
------------

// File: rtl/result_deser_pkg.sv
// Shared types and constants for the result deserializer.
// Optional build macro: RESULT_DESER_PARITY_EN (adds a stored even-parity bit per word).
package result_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Word assembly states: IDLE has no bits, SHIFT is mid-word, LAST holds a full word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LAST  = 2'd2
    } state_t;

    // Even parity: the returned bit makes the total number of ones even.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding assembled words; the read port shows zero when empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == {(AW+1){1'b0}});
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign level     = r_level;
    assign rdata     = empty ? {WIDTH{1'b0}} : r_mem[r_rd];

    // Storage array written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr] <= wdata;
        end else begin
            r_mem[r_wr] <= r_mem[r_wr];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= {AW{1'b0}};
            r_rd    <= {AW{1'b0}};
            r_level <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end else begin
                r_wr <= r_wr;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end else begin
                r_rd <= r_rd;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/result_deser.sv
// Serial-to-parallel result deserializer: collects WIDTH valid bits LSB-first into a
// word and queues finished words in a small FIFO for a ready/valid consumer.
// Optional build macro: RESULT_DESER_PARITY_EN adds port par_o and a stored parity bit.
module result_deser
    import result_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     c_in,
    input  logic                     c_vld,
    input  logic                     flush,
    output logic [WIDTH-1:0]         data_o,
    output logic                     data_vld_o,
    input  logic                     data_rdy_i,
    output logic [$clog2(DEPTH):0]   level_o,
`ifdef RESULT_DESER_PARITY_EN
    output logic                     par_o,
`endif
    output logic                     ovf_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`ifdef RESULT_DESER_PARITY_EN
    localparam int FW = WIDTH + 1;
`else
    localparam int FW = WIDTH;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_ovf;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic [FW-1:0]    w_wdata;
    logic [FW-1:0]    w_rdata;

    // A flush swallows any bit presented in the same cycle.
    assign w_accept = c_vld & ~flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a bit arriving in LAST starts the next word without a bubble.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = c_vld ? SHIFT : IDLE;
                SHIFT:   w_next = (c_vld && (r_cnt == LAST_CNT)) ? LAST : SHIFT;
                LAST:    w_next = c_vld ? SHIFT : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Output logic: the full word sits in the shift register for exactly the LAST cycle.
    always_comb begin
        w_push = 1'b0;
        case (r_state)
            LAST:    w_push = 1'b1;
            default: w_push = 1'b0;
        endcase
    end

    // Bit counter of the word in progress; it is zero in IDLE and LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (flush) begin
            r_cnt <= {CW{1'b0}};
        end else if (c_vld) begin
            r_cnt <= (r_cnt == LAST_CNT) ? {CW{1'b0}} : r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Right shift so that after WIDTH bits the first accepted bit lands in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_shift <= {c_in, r_shift[WIDTH-1:1]};
        end else begin
            r_shift <= r_shift;
        end
    end

    assign w_pop = data_rdy_i & ~w_empty;

    // Sticky overflow: a push dropped because the FIFO was full with no pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (w_push & w_full & ~w_pop);
        end
    end

`ifdef RESULT_DESER_PARITY_EN
    assign w_wdata = {even_parity(32'(r_shift)), r_shift};
    assign par_o   = w_rdata[WIDTH];
`else
    assign w_wdata = r_shift;
`endif

    result_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (level_o)
    );

    assign data_o     = w_rdata[WIDTH-1:0];
    assign data_vld_o = ~w_empty;
    assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_result_deser.sv
// Directed testbench for result_deser with a queue-based reference model.
module tb_result_deser;

    localparam int W = 8;
    localparam int D = 4;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic c_in       = 1'b0;
    logic c_vld      = 1'b0;
    logic flush      = 1'b0;
    logic data_rdy_i = 1'b0;
    wire [W-1:0] data_o;
    wire         data_vld_o;
    wire [2:0]   level_o;
    wire         ovf_o;
`ifdef RESULT_DESER_PARITY_EN
    wire         par_o;
`endif

    always #5 clk = ~clk;

    result_deser #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c_in       (c_in),
        .c_vld      (c_vld),
        .flush      (flush),
        .data_o     (data_o),
        .data_vld_o (data_vld_o),
        .data_rdy_i (data_rdy_i),
        .level_o    (level_o),
`ifdef RESULT_DESER_PARITY_EN
        .par_o      (par_o),
`endif
        .ovf_o      (ovf_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bits collect in a list; a full word is queued one edge later.
    logic [W-1:0] mq[$];
    bit           mbits[$];
    bit           m_pend;
    logic [W-1:0] m_pword;
    bit           m_ovf;
    bit           m_pop;
    logic [W-1:0] m_tmp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mbits.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_pop = (mq.size() > 0) && data_rdy_i;
            if (m_pop) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() == D) m_ovf = 1'b1;
                else mq.push_back(m_pword);
            end
            m_pend = 1'b0;
            if (flush) begin
                mbits.delete();
            end else if (c_vld) begin
                mbits.push_back(c_in);
                if (mbits.size() == W) begin
                    m_tmp = '0;
                    for (int i = 0; i < W; i++) m_tmp[i] = mbits[i];
                    m_pword = m_tmp;
                    m_pend  = 1'b1;
                    mbits.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model plus a log of consumed words.
    bit           chk_en = 1'b0;
    logic [W-1:0] popped[$];
    int           max_lvl = 0;
    logic [W-1:0] exp_d;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_d = (mq.size() > 0) ? mq[0] : '0;
            check("cyc_data_o", 32'(data_o), 32'(exp_d));
            check("cyc_data_vld_o", 32'(data_vld_o), 32'(mq.size() > 0));
            check("cyc_level_o", 32'(level_o), 32'(mq.size()));
            check("cyc_ovf_o", 32'(ovf_o), 32'(m_ovf));
`ifdef RESULT_DESER_PARITY_EN
            check("cyc_par_o", 32'(par_o), 32'((mq.size() > 0) ? ^exp_d : 1'b0));
`endif
            if (data_vld_o && data_rdy_i) popped.push_back(data_o);
            if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            c_vld = 1'b1;
            c_in  = w[i];
            @(posedge clk);
            #1;
        end
        c_vld = 1'b0;
        c_in  = 1'b0;
    endtask

    initial begin
        // Reset state
        idle(1);
        chk_en = 1'b1;
        idle(1);
        check("rst_data_o", 32'(data_o), 32'h0);
        check("rst_vld", 32'(data_vld_o), 32'h0);
        check("rst_level", 32'(level_o), 32'h0);
        check("rst_ovf", 32'(ovf_o), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Bits 1,0,1,1,0,0,0,1 -> 8'h8D, valid one cycle after the 8th bit
        send_word(8'h8D);
        check("t1_vld_early", 32'(data_vld_o), 32'h0);
        idle(1);
        check("t1_vld", 32'(data_vld_o), 32'h1);
        check("t1_data", 32'(data_o), 32'h8D);
        data_rdy_i = 1'b1;
        idle(1);
        data_rdy_i = 1'b0;
        check("t1_drained", 32'(level_o), 32'h0);

        // Back-to-back FF then 00 with the consumer always ready
        popped.delete();
        max_lvl = 0;
        data_rdy_i = 1'b1;
        send_word(8'hFF);
        send_word(8'h00);
        idle(3);
        data_rdy_i = 1'b0;
        check("t2_count", 32'(popped.size()), 32'd2);
        check("t2_word0", 32'(popped[0]), 32'hFF);
        check("t2_word1", 32'(popped[1]), 32'h00);
        check("t2_maxlvl", 32'(max_lvl), 32'd1);

        // Five words into a four-deep FIFO with no consumer
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        send_word(8'h55);
        idle(2);
        check("t3_level", 32'(level_o), 32'd4);
        check("t3_ovf", 32'(ovf_o), 32'h1);
        check("t3_head", 32'(data_o), 32'h11);
        popped.delete();
        data_rdy_i = 1'b1;
        idle(6);
        data_rdy_i = 1'b0;
        check("t3_count", 32'(popped.size()), 32'd4);
        check("t3_last", 32'(popped[3]), 32'h44);

        // Full FIFO: push and pop in the same cycle keep the level
        send_word(8'h61);
        send_word(8'h62);
        send_word(8'h63);
        send_word(8'h64);
        send_word(8'h65);
        data_rdy_i = 1'b1;
        idle(1);
        data_rdy_i = 1'b0;
        check("t3b_level", 32'(level_o), 32'd4);
        check("t3b_head", 32'(data_o), 32'h62);
        popped.delete();
        data_rdy_i = 1'b1;
        idle(5);
        data_rdy_i = 1'b0;
        check("t3b_count", 32'(popped.size()), 32'd4);
        check("t3b_last", 32'(popped[3]), 32'h65);

        // Three bits, a flush (its own bit is discarded), then 8'h5A
        for (int i = 0; i < 3; i++) begin
            c_vld = 1'b1;
            c_in  = 1'b1;
            idle(1);
        end
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        c_vld = 1'b0;
        send_word(8'h5A);
        idle(1);
        check("t4_data", 32'(data_o), 32'h5A);
        check("t4_level", 32'(level_o), 32'd1);
        data_rdy_i = 1'b1;
        idle(1);
        data_rdy_i = 1'b0;

        // Flush during LAST still delivers the word
        send_word(8'hC3);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("t4b_data", 32'(data_o), 32'hC3);
        check("t4b_level", 32'(level_o), 32'd1);

        // Reset mid-word clears everything at once
        for (int i = 0; i < 4; i++) begin
            c_vld = 1'b1;
            c_in  = 1'b1;
            idle(1);
        end
        c_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_data", 32'(data_o), 32'h0);
        check("t5_vld", 32'(data_vld_o), 32'h0);
        check("t5_level", 32'(level_o), 32'h0);
        check("t5_ovf", 32'(ovf_o), 32'h0);
        idle(2);
        rst_n = 1'b1;
        send_word(8'h3C);
        idle(1);
        check("t5_word", 32'(data_o), 32'h3C);

`ifdef RESULT_DESER_PARITY_EN
        data_rdy_i = 1'b1;
        idle(1);
        data_rdy_i = 1'b0;
        send_word(8'h07);
        idle(1);
        check("t6_data", 32'(data_o), 32'h07);
        check("t6_par", 32'(par_o), 32'h1);
`endif

        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
